multicore_system_ctrl: RTL and testbench

- Top-level sequencer and shared-memory arbiter for a system with NUM_CORES CPU cores, one program loader and one single-port RAM.
- Sequences IDLE -> LOADING -> EXECUTING -> HALTED.
- Arbitrates RAM access among cores round-robin, tracks per-core halt, and enforces a run-time watchdog.
- Supports restart from HALTED/TIMEOUT without reset.

---
 rtl/multicore_system_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicore_system_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicore_system_ctrl.sv
// Top-level sequencer and shared single-port RAM arbiter for a multicore system.
// Handles load/run/halt sequencing, round-robin core arbitration and a run watchdog.
module multicore_system_ctrl #(
  parameter int unsigned NUM_CORES      = 2,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  output logic                          ld_start,
  input  logic                          ld_done,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DATA_W-1:0]             ld_wdata,
  input  logic                          ld_we,
  output logic [NUM_CORES-1:0]          core_exec,
  input  logic [NUM_CORES-1:0]          core_halted,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_gnt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  output logic                          mem_re,
  output logic [2:0]                    sys_state,
  output logic [NUM_CORES-1:0]          halted_mask,
  output logic [CNT_W-1:0]              cycle_count,
  output logic                          timeout
);

  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOADING   = 3'd1,
    ST_EXECUTING = 3'd2,
    ST_HALTED    = 3'd3,
    ST_TIMEOUT   = 3'd4
  } state_t;

  state_t               state, state_next;
  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] gnt;
  logic                 gnt_valid;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 all_halted;
  logic                 wd_hit;

  // Round-robin search: cores at or above the pointer first, then wrap to the low cores.
  always_comb begin
    eligible  = core_req & ~halted_mask;
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (state == ST_EXECUTING) begin
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        if (!gnt_valid && eligible[i] && (PTR_W'(i) >= rr_ptr)) begin
          gnt_valid = 1'b1;
          gnt_idx   = PTR_W'(i);
          gnt[i]    = 1'b1;
        end
      end
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        if (!gnt_valid && eligible[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = PTR_W'(i);
          gnt[i]    = 1'b1;
        end
      end
    end
  end

  // RAM port mux: loader owns the RAM while loading, the granted core while executing.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (state == ST_LOADING) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_we    = ld_we;
    end else begin
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        if (gnt[i]) begin
          mem_addr  = core_addr[i*ADDR_W +: ADDR_W];
          mem_wdata = core_wdata[i*DATA_W +: DATA_W];
          mem_we    = core_we[i];
          mem_re    = ~core_we[i];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; abort overrides everything, all-halt beats the watchdog.
  always_comb begin
    state_next = state;
    all_halted = &(halted_mask | core_halted);
    wd_hit     = WD_EN && (cycle_count == WD_LIMIT);
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (start) state_next = ST_LOADING;
        ST_LOADING:   if (ld_done) state_next = ST_EXECUTING;
        ST_EXECUTING: begin
          if (all_halted)  state_next = ST_HALTED;
          else if (wd_hit) state_next = ST_TIMEOUT;
        end
        ST_HALTED,
        ST_TIMEOUT:   if (start) state_next = ST_LOADING;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // Run bookkeeping: pointer, sticky halt flags, run cycle counter, watchdog flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      halted_mask <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else begin
      if (gnt_valid) rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      if (!abort) begin
        if (state == ST_LOADING && ld_done) begin
          halted_mask <= '0;
          cycle_count <= '0;
        end else if (state == ST_EXECUTING) begin
          halted_mask <= halted_mask | core_halted;
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
        end
      end
      if (state_next == ST_LOADING && state != ST_LOADING) timeout <= 1'b0;
      else if (state == ST_EXECUTING && state_next == ST_TIMEOUT) timeout <= 1'b1;
    end
  end

  assign sys_state = state;
  assign ld_start  = (state == ST_LOADING);
  assign core_exec = (state == ST_EXECUTING) ? ~halted_mask : '0;
  assign core_gnt  = gnt;

endmodule

// File: tb/tb_multicore_system_ctrl.sv
// Bench for multicore_system_ctrl: directed phases with random data, checked
// every cycle against a behavioural model of the sequencer and arbiter.
module tb_multicore_system_ctrl;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 24;
  localparam int unsigned CW = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic            start, abort, ld_start, ld_done, ld_we;
  logic [AW-1:0]   ld_addr;
  logic [DW-1:0]   ld_wdata;
  logic [N-1:0]    core_exec, core_halted, core_req, core_we, core_gnt;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we, mem_re, timeout;
  logic [2:0]      sys_state;
  logic [N-1:0]    halted_mask;
  logic [CW-1:0]   cycle_count;

  multicore_system_ctrl #(
    .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .ld_start(ld_start), .ld_done(ld_done), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_we(ld_we),
    .core_exec(core_exec), .core_halted(core_halted), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .sys_state(sys_state), .halted_mask(halted_mask), .cycle_count(cycle_count), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model state: 0 idle, 1 loading, 2 executing, 3 halted, 4 timeout
  int           m_st;
  logic [N-1:0] m_mask;
  int           m_count;
  bit           m_to;
  int           m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_mask = '0; m_count = 0; m_to = 0; m_rr = 0;
  endtask

  // Index of the core the arbiter should pick, or -1.
  function automatic int pick();
    int k = -1;
    if (m_st != 2) return -1;
    for (int o = 0; o < int'(N); o++) begin
      int idx;
      idx = (m_rr + o) % int'(N);
      if (k < 0 && core_req[idx] && !m_mask[idx]) k = idx;
    end
    return k;
  endfunction

  task automatic check_outputs();
    int k;
    logic [N-1:0]  eg, ee;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit ewe, ere;
    eg = '0; ea = '0; ed = '0; ewe = 0; ere = 0;
    k  = pick();
    ee = (m_st == 2) ? ~m_mask : '0;
    if (m_st == 1) begin ea = ld_addr; ed = ld_wdata; ewe = ld_we; end
    if (k >= 0) begin
      eg[k] = 1'b1;
      ea  = core_addr[k*AW +: AW];
      ed  = core_wdata[k*DW +: DW];
      ewe = core_we[k];
      ere = !core_we[k];
    end
    chk("sys_state",   32'(sys_state),   32'(m_st));
    chk("ld_start",    32'(ld_start),    32'(m_st == 1));
    chk("core_exec",   32'(core_exec),   32'(ee));
    chk("core_gnt",    32'(core_gnt),    32'(eg));
    chk("mem_addr",    32'(mem_addr),    32'(ea));
    chk("mem_wdata",   32'(mem_wdata),   32'(ed));
    chk("mem_we",      32'(mem_we),      32'(ewe));
    chk("mem_re",      32'(mem_re),      32'(ere));
    chk("halted_mask", 32'(halted_mask), 32'(m_mask));
    chk("cycle_count", 32'(cycle_count), 32'(m_count));
    chk("timeout",     32'(timeout),     32'(m_to));
  endtask

  task automatic model_next();
    int k, old;
    k = pick();
    if (k >= 0) m_rr = (k + 1) % int'(N);
    if (abort) begin m_st = 0; return; end
    case (m_st)
      0: if (start) begin m_st = 1; m_to = 0; end
      1: if (ld_done) begin m_st = 2; m_mask = '0; m_count = 0; end
      2: begin
        old = m_count;
        m_mask = m_mask | core_halted;
        if (m_count < (1 << CW) - 1) m_count++;
        if (&m_mask) m_st = 3;
        else if (old == int'(TO) - 1) begin m_st = 4; m_to = 1; end
      end
      default: if (start) begin m_st = 1; m_to = 0; end
    endcase
  endtask

  task automatic cycle();
    @(negedge clock);
    check_outputs();
    model_next();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_data();
    ld_addr    = AW'($urandom);
    ld_wdata   = DW'($urandom);
    ld_we      = 1'($urandom);
    core_we    = N'($urandom);
    core_addr  = (N*AW)'($urandom);
    core_wdata = (N*DW)'($urandom);
  endtask

  task automatic clear_ctl();
    start = 0; abort = 0; ld_done = 0; core_halted = '0; core_req = '0;
  endtask

  task automatic boot();
    start = 1; cycle(); start = 0;
    rand_data(); ld_done = 1; cycle(); ld_done = 0;
  endtask

  initial begin
    int guard;
    reset = 1;
    clear_ctl();
    rand_data();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    #1;
    reset = 0;

    // Boot with ld_done after 5 loading cycles
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 5; i++) begin rand_data(); cycle(); end
    rand_data(); ld_done = 1; cycle(); ld_done = 0;
    chk("boot_state", 32'(sys_state), 32'd2);
    chk("boot_exec",  32'(core_exec), 32'h3);
    chk("boot_count", 32'(cycle_count), 32'd0);

    // Both cores requesting continuously alternate grants
    for (int i = 0; i < 6; i++) begin
      core_req = 2'b11; rand_data();
      @(negedge clock);
      chk("rr_gnt", 32'(core_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      check_outputs(); model_next();
      @(posedge clock); #1;
    end

    // Staggered halts at counts 10 and 20
    guard = 0;
    while (m_st == 2 && guard < 100) begin
      core_req = N'($urandom) | 2'b01; rand_data();
      core_halted = (m_count == 10) ? 2'b01 : (m_count == 20) ? 2'b10 : 2'b00;
      @(negedge clock);
      if (m_mask[0]) chk("no_gnt_core0", 32'(core_gnt[0]), 32'd0);
      check_outputs(); model_next();
      @(posedge clock); #1;
      guard++;
    end
    core_halted = '0; core_req = '0;
    chk("halt_state", 32'(sys_state), 32'd3);
    chk("halt_mask",  32'(halted_mask), 32'h3);
    chk("halt_count", 32'(cycle_count), 32'd21);

    // Watchdog with no halts
    boot();
    guard = 0;
    while (m_st == 2 && guard < 100) begin
      core_req = N'($urandom); rand_data(); cycle(); guard++;
    end
    core_req = '0;
    chk("wd_state",   32'(sys_state), 32'd4);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_exec",    32'(core_exec), 32'd0);
    chk("wd_count",   32'(cycle_count), 32'(TO));
    start = 1; cycle(); start = 0;
    chk("restart_state",   32'(sys_state), 32'd1);
    chk("restart_timeout", 32'(timeout), 32'd0);

    // Final halt coincides with the watchdog limit
    rand_data(); ld_done = 1; cycle(); ld_done = 0;
    guard = 0;
    while (m_st == 2 && guard < 100) begin
      core_req = N'($urandom); rand_data();
      core_halted = (m_count == 3) ? 2'b01 : (m_count == int'(TO) - 1) ? 2'b10 : 2'b00;
      cycle(); guard++;
    end
    core_halted = '0; core_req = '0;
    chk("tie_state",   32'(sys_state), 32'd3);
    chk("tie_timeout", 32'(timeout), 32'd0);

    // Abort with start in EXECUTING
    boot();
    for (int i = 0; i < 3; i++) begin core_req = N'($urandom); rand_data(); cycle(); end
    abort = 1; start = 1; cycle(); abort = 0; start = 0;
    chk("abort_state", 32'(sys_state), 32'd0);
    chk("abort_exec",  32'(core_exec), 32'd0);

    // Random traffic with occasional control events
    for (int i = 0; i < 600; i++) begin
      start       = ($urandom % 6) == 0;
      abort       = ($urandom % 40) == 0;
      ld_done     = ($urandom % 4) == 0;
      core_req    = N'($urandom);
      core_halted = (($urandom % 12) == 0) ? N'($urandom) : '0;
      rand_data();
      cycle();
    end
    clear_ctl();

    // Asynchronous reset while loading
    abort = 1; cycle(); abort = 0;
    start = 1; cycle(); start = 0;
    rand_data();
    chk("pre_rst_state", 32'(sys_state), 32'd1);
    #2;
    reset = 1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_ld_start", 32'(ld_start), 32'd0);
    chk("rst_mem_we",   32'(mem_we), 32'd0);
    @(posedge clock); #1;
    reset = 0;
    for (int i = 0; i < 4; i++) begin start = (i == 0); rand_data(); cycle(); end
    start = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
